// File: rtl/mole_hit_judge.sv
// Whack-a-mole hit judge: latches mole positions, scores hits, counts misses, requests new positions.
// Define MOLE_WRONG_PENALTY_EN to make a wrong press in ARMED cost one point (floored at 0).
module mole_hit_judge #(
  parameter int SCORE_W      = 7,
  parameter int MAX_MISSES   = 3,
  parameter int HIT_TIMEOUT  = 16,
  parameter int FLASH_CYCLES = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [2:0]         i_mole_position,
  input  logic               i_position_changed,
  input  logic [4:0]         i_btn,
  input  logic               i_restart,
  output logic               o_change_position,
  output logic [SCORE_W-1:0] o_score,
  output logic [3:0]         o_misses,
  output logic               o_game_over,
  output logic               o_hit_flash
);

  localparam int TMO_W   = (HIT_TIMEOUT > 2) ? $clog2(HIT_TIMEOUT) : 1;
  localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ARMED, WAIT_CHG, OVER} state_t;

  state_t             state_q, state_d;
  logic [2:0]         mole_q, mole_d;
  logic [4:0]         btn_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         misses_q, misses_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [FLASH_W-1:0] flash_q, flash_d;
  logic               change_q, change_d;

  logic [4:0] press;
  logic [7:0] press_ext;
  logic       hit;
  logic       wrong_press;
  logic       new_pos_valid;
  logic [3:0] misses_inc;

  // Positions 5-7 mean "no mole", so the padded press vector can never hit there.
  always_comb begin
    press         = i_btn & ~btn_q;
    press_ext     = {3'b000, press};
    hit           = press_ext[mole_q];
    wrong_press   = (press != 5'd0) && !hit;
    new_pos_valid = (i_mole_position < 3'd5);
    misses_inc    = (misses_q >= 4'(MAX_MISSES)) ? misses_q : misses_q + 4'd1;
  end

  always_comb begin
    state_d  = state_q;
    mole_d   = mole_q;
    score_d  = score_q;
    misses_d = misses_q;
    tmo_d    = tmo_q;
    change_d = 1'b0;
    flash_d  = (flash_q != '0) ? flash_q - 1'b1 : flash_q;

    if (i_restart) begin
      score_d  = '0;
      misses_d = '0;
      flash_d  = '0;
      tmo_d    = '0;
      mole_d   = 3'd5;
      state_d  = IDLE;
      change_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_position_changed) begin
            mole_d  = i_mole_position;
            state_d = new_pos_valid ? ARMED : IDLE;
          end
        end
        ARMED: begin
          if (hit) begin
            score_d = (score_q == '1) ? score_q : score_q + 1'b1;
            flash_d = FLASH_W'(FLASH_CYCLES);
            // A hit racing a strobe is scored, but the generator already moved on, so no request.
            if (i_position_changed) begin
              mole_d  = i_mole_position;
              state_d = new_pos_valid ? ARMED : IDLE;
            end else begin
              change_d = 1'b1;
              tmo_d    = '0;
              state_d  = WAIT_CHG;
            end
          end else begin
`ifdef MOLE_WRONG_PENALTY_EN
            if (wrong_press && (score_q != '0)) begin
              score_d = score_q - 1'b1;
            end
`endif
            if (i_position_changed) begin
              misses_d = misses_inc;
              mole_d   = i_mole_position;
              if (misses_inc == 4'(MAX_MISSES)) begin
                state_d = OVER;
              end else begin
                state_d = new_pos_valid ? ARMED : IDLE;
              end
            end
          end
        end
        WAIT_CHG: begin
          if (i_position_changed) begin
            mole_d  = i_mole_position;
            state_d = new_pos_valid ? ARMED : IDLE;
          end else if (tmo_q == TMO_W'(HIT_TIMEOUT - 1)) begin
            change_d = 1'b1;
            tmo_d    = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      mole_q   <= 3'd5;
      btn_q    <= '0;
      score_q  <= '0;
      misses_q <= '0;
      tmo_q    <= '0;
      flash_q  <= '0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mole_q   <= mole_d;
      btn_q    <= i_btn;
      score_q  <= score_d;
      misses_q <= misses_d;
      tmo_q    <= tmo_d;
      flash_q  <= flash_d;
      change_q <= change_d;
    end
  end

  assign o_change_position = change_q;
  assign o_score           = score_q;
  assign o_misses          = misses_q;
  assign o_game_over       = (state_q == OVER);
  assign o_hit_flash       = (flash_q != '0);

endmodule
